// File: rtl/frq_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frq_seq_ctrl_if
// Purpose  : Bundles the frame request, divider handshake and status signals
//            of frq_seq_ctrl.
//   master : frame requester / divider side (drives start, msg, SW, co)
//   slave  : frq_seq_ctrl itself (drives div_ld, div_SW, sel, ser_out,
//            busy, done, err)
// Signals  : start   - request to transmit one frame
//            msg     - 5-bit frame payload, sent MSB first
//            SW      - 3-bit divider ratio select for the frame
//            co      - divider carry-out tick (one-cycle pulse)
//            div_ld  - one-cycle load strobe to the loadable divider
//            div_SW  - latched SW driven to the divider
//            sel     - divider mux select (1 = loadable, 0 = free-running)
//            ser_out - serial frame bit (idles high)
//            busy    - frame active
//            done    - one-cycle completion pulse
//            err     - one-cycle timeout pulse
// Revision : 1.0 - initial release
// ============================================================================
interface frq_seq_ctrl_if;
    logic       start;
    logic [4:0] msg;
    logic [2:0] SW;
    logic       co;
    logic       div_ld;
    logic [2:0] div_SW;
    logic       sel;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, msg, SW, co,
        input  div_ld, div_SW, sel, ser_out, busy, done, err
    );

    modport slave (
        input  start, msg, SW, co,
        output div_ld, div_SW, sel, ser_out, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/frq_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frq_seq_ctrl
// Purpose  : Frame sequencer that loads a divider ratio, then shifts a 5-bit
//            payload out MSB first, one bit per divider carry-out tick.
//            Aborts with an err pulse if the divider stays silent for
//            TIMEOUT cycles while sending.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - frq_seq_ctrl_if.slave (request, divider and status)
// Params   : TIMEOUT - max SEND cycles without co before abort
// Macros   : FRQ_SEQ_PARITY_EN - when defined, an even-parity bit (XOR of
//            msg) is appended, making the frame 6 bits long
// Revision : 1.0 - initial release
// ============================================================================
module frq_seq_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    frq_seq_ctrl_if.slave     bus
);

`ifdef FRQ_SEQ_PARITY_EN
    localparam int c_NBITS = 6;
`else
    localparam int c_NBITS = 5;
`endif

    localparam logic [2:0] c_LAST_BIT = 3'(c_NBITS - 1);
    localparam int         c_WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_NBITS-1:0]    r_shift;
    logic [2:0]            r_bit_cnt;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [2:0]            r_div_sw;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                // A co tick takes priority over a simultaneous timeout.
                if (bus.co) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = DONE;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: payload shifter, bit counter, silence counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_wait    <= '0;
            r_div_sw  <= '0;
            r_err     <= 1'b0;
        end else begin
            // err is registered so it appears in the first IDLE cycle.
            r_err <= w_abort;
            if (w_accept) begin
`ifdef FRQ_SEQ_PARITY_EN
                r_shift <= {bus.msg, ^bus.msg};
`else
                r_shift <= bus.msg;
`endif
                r_div_sw  <= bus.SW;
                r_bit_cnt <= '0;
                r_wait    <= '0;
            end else if (r_state == SEND) begin
                if (bus.co) begin
                    r_shift   <= {r_shift[c_NBITS-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_wait    <= '0;
                end else begin
                    r_wait    <= r_wait + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // ------------------------------------------------------------------
    assign bus.div_ld  = (r_state == LOAD);
    assign bus.div_SW  = r_div_sw;
    assign bus.busy    = (r_state != IDLE);
    assign bus.sel     = (r_state != IDLE);
    assign bus.ser_out = (r_state == SEND) ? r_shift[c_NBITS-1] : 1'b1;
    assign bus.done    = (r_state == DONE);
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frq_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frq_seq_ctrl
// Purpose  : Self-checking bench for frq_seq_ctrl. A cycle-level reference
//            model tracks bits sent and silent cycles and predicts the
//            serial line, status outputs and frame outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frq_seq_ctrl;

    localparam int TB_TIMEOUT = 8;
`ifdef FRQ_SEQ_PARITY_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frq_seq_ctrl_if bus ();

    frq_seq_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},    8'(bus.busy),    8'd0);
        chk({tag, "_sel"},     8'(bus.sel),     8'd0);
        chk({tag, "_ser_out"}, 8'(bus.ser_out), 8'd1);
        chk({tag, "_div_ld"},  8'(bus.div_ld),  8'd0);
        chk({tag, "_done"},    8'(bus.done),    8'd0);
    endtask

    // Bit idx of the frame: payload MSB first, then optional even parity.
    function automatic logic frame_bit(input logic [4:0] m, input int idx);
        if (idx < 5) return m[4 - idx];
        return ^m;
    endfunction

    // co_mode: 0 = co on every period-th SEND cycle, 1 = random co, 2 = no co.
    // hold: keep start high and drive msg=00001 after acceptance.
    // rst_bit: assert rst while that bit index is on the line (-1 = never).
    task automatic run_frame(input logic [4:0] m, input logic [2:0] sw,
                             input int co_mode, input int period,
                             input bit hold, input int rst_bit);
        int   k   = 0;
        int   wt  = 0;
        int   cyc = 0;
        bit   fin_done = 0;
        bit   fin_err  = 0;
        logic c;

        bus.start = 1'b1;
        bus.msg   = m;
        bus.SW    = sw;
        bus.co    = 1'($urandom_range(0, 1));
        tick();
        // LOAD cycle
        chk("load_div_ld",  8'(bus.div_ld),  8'd1);
        chk("load_div_SW",  8'(bus.div_SW),  8'(sw));
        chk("load_busy",    8'(bus.busy),    8'd1);
        chk("load_sel",     8'(bus.sel),     8'd1);
        chk("load_ser_out", 8'(bus.ser_out), 8'd1);
        chk("load_done",    8'(bus.done),    8'd0);
        bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        bus.msg   = hold ? 5'b00001 : 5'($urandom);
        bus.SW    = 3'($urandom);
        bus.co    = 1'($urandom_range(0, 1));   // must be ignored in LOAD
        tick();

        while (!fin_done && !fin_err && cyc < 200) begin
            chk("send_ser_out", 8'(bus.ser_out), 8'(frame_bit(m, k)));
            chk("send_busy",    8'(bus.busy),    8'd1);
            chk("send_sel",     8'(bus.sel),     8'd1);
            chk("send_div_ld",  8'(bus.div_ld),  8'd0);
            chk("send_done",    8'(bus.done),    8'd0);
            chk("send_err",     8'(bus.err),     8'd0);
            chk("send_div_SW",  8'(bus.div_SW),  8'(sw));
            case (co_mode)
                0:       c = ((cyc % period) == period - 1);
                1:       c = ($urandom_range(0, 2) == 0);
                default: c = 1'b0;
            endcase
            cyc++;
            bus.co    = c;
            bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            bus.msg   = hold ? 5'b00001 : 5'($urandom);
            bus.SW    = 3'($urandom);
            if (rst_bit >= 0 && k == rst_bit) begin
                rst = 1'b1;
                tick();
                rst       = 1'b0;
                bus.start = 1'b0;
                bus.co    = 1'b0;
                check_idle("midrst");
                chk("midrst_div_SW", 8'(bus.div_SW), 8'd0);
                chk("midrst_err",    8'(bus.err),    8'd0);
                tick();
                check_idle("midrst_after");
                return;
            end
            tick();
            if (c) begin
                k++;
                wt = 0;
                if (k == NB) fin_done = 1;
            end else begin
                wt++;
                if (wt == TB_TIMEOUT) fin_err = 1;
            end
        end

        if (!fin_done && !fin_err) begin
            chk("frame_bound", 8'd0, 8'd1);
        end else if (fin_done) begin
            chk("done_done",    8'(bus.done),    8'd1);
            chk("done_busy",    8'(bus.busy),    8'd1);
            chk("done_sel",     8'(bus.sel),     8'd1);
            chk("done_err",     8'(bus.err),     8'd0);
            chk("done_ser_out", 8'(bus.ser_out), 8'd1);
            chk("done_div_ld",  8'(bus.div_ld),  8'd0);
            bus.co = 1'($urandom_range(0, 1));
            tick();
            check_idle("post_done");
            chk("post_done_err", 8'(bus.err), 8'd0);
        end else begin
            chk("timeout_err",     8'(bus.err),     8'd1);
            chk("timeout_busy",    8'(bus.busy),    8'd0);
            chk("timeout_done",    8'(bus.done),    8'd0);
            chk("timeout_sel",     8'(bus.sel),     8'd0);
            chk("timeout_ser_out", 8'(bus.ser_out), 8'd1);
            bus.start = 1'b0;
            bus.co    = 1'b0;
            tick();
            chk("timeout_err_pulse", 8'(bus.err), 8'd0);
            check_idle("post_timeout");
        end
        bus.start = 1'b0;
        bus.co    = 1'b0;
    endtask

    initial begin
        // Reset with start asserted: reset must dominate.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.msg   = 5'b10110;
        bus.SW    = 3'b101;
        bus.co    = 1'b0;
        tick();
        tick();
        check_idle("reset");
        chk("reset_div_SW", 8'(bus.div_SW), 8'd0);
        chk("reset_err",    8'(bus.err),    8'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check_idle("idle");

        // Reference frame, co every 4 cycles.
        run_frame(5'b10110, 3'b011, 0, 4, 1'b0, -1);
        // start held, msg changed after acceptance.
        run_frame(5'b10110, 3'b011, 0, 4, 1'b1, -1);
        // No co at all: timeout.
        run_frame(5'($urandom), 3'($urandom), 2, 0, 1'b0, -1);
        // co arrives on the cycle the silence count would reach TIMEOUT.
        run_frame(5'($urandom), 3'($urandom), 0, TB_TIMEOUT, 1'b0, -1);
        // One cycle too late: timeout.
        run_frame(5'($urandom), 3'($urandom), 0, TB_TIMEOUT + 1, 1'b0, -1);
        // co every cycle.
        run_frame(5'($urandom), 3'($urandom), 0, 1, 1'b0, -1);
        // Parity reference patterns.
        run_frame(5'b10110, 3'b001, 0, 2, 1'b0, -1);
        run_frame(5'b10100, 3'b110, 0, 3, 1'b0, -1);
        // Reset while the 3rd bit is on the line.
        run_frame(5'b10110, 3'b011, 0, 3, 1'b0, 2);
        // Randomised frames.
        for (int i = 0; i < 20; i++) begin
            run_frame(5'($urandom), 3'($urandom), 1, 0, 1'($urandom_range(0, 1)), -1);
        end
        // Random mid-frame reset.
        run_frame(5'($urandom), 3'($urandom), 0, 2, 1'b0, int'($urandom_range(0, NB - 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
